// File: rtl/gamepad_pmod_driver_pkg.sv
// Shared definitions for the gamepad PMOD transmit driver.
//   - FSM state encoding
//   - frame geometry: two controllers of twelve buttons, serialised as one frame
package gamepad_pmod_driver_pkg;

   localparam int BUTTONS_PER_PAD = 12;
   localparam int NUM_PADS        = 2;
   localparam int NUM_BITS        = NUM_PADS * BUTTONS_PER_PAD;
   localparam int IDX_W           = 5;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SHIFT_LO,
      SHIFT_HI,
      GAP
   } state_e;

endpackage

// File: rtl/gamepad_pmod_driver_if.sv
// Bundle of the driver's user-side controls and the three-wire PMOD link.
//   enable, buttons_a, buttons_b : frame request and button state (into driver)
//   game_latch, game_clk, game_data : serial link (out of driver)
//   busy, frame_done : frame status (out of driver)
// master = the driver, slave = whoever feeds buttons and listens to the link.
interface gamepad_pmod_driver_if;
   import gamepad_pmod_driver_pkg::*;

   logic                       enable;
   logic [BUTTONS_PER_PAD-1:0] buttons_a;
   logic [BUTTONS_PER_PAD-1:0] buttons_b;
   logic                       game_latch;
   logic                       game_clk;
   logic                       game_data;
   logic                       busy;
   logic                       frame_done;

   modport master (
      input  enable, buttons_a, buttons_b,
      output game_latch, game_clk, game_data, busy, frame_done
   );

   modport slave (
      output enable, buttons_a, buttons_b,
      input  game_latch, game_clk, game_data, busy, frame_done
   );

endinterface

// File: rtl/gamepad_pmod_clkdiv.sv
// Reloadable down-counter with a registered terminal-count strobe.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : reload the counter with load_val_i this cycle
//   load_val_i  : number of cycles until the strobe (>=1)
//   tc_o        : high during the last counted cycle (count == 1)
// After the terminal cycle the count drops to 0 and holds until reloaded.
module gamepad_pmod_clkdiv #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q,  tc_d;

   always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      if (load_i) begin
         cnt_d = load_val_i;
         tc_d  = (load_val_i == WIDTH'(1));
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - WIDTH'(1);
         tc_d  = (cnt_q == WIDTH'(2));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign tc_o = tc_q;

endmodule

// File: rtl/gamepad_pmod_driver.sv
// Transmit end of the three-wire gamepad PMOD link.
// Snapshots {buttons_b, buttons_a} at each latch and shifts it out MSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gamepad_pmod_driver_if.master (enable/buttons in; link + status out)
// Frame: latch high 2*CLK_DIV, 24 game_clk periods of 2*CLK_DIV, FRAME_GAP idle.
// All outputs come straight from flops.
module gamepad_pmod_driver
   import gamepad_pmod_driver_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int FRAME_GAP = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gamepad_pmod_driver_if.master bus
);

   localparam int HP_W  = $clog2(2 * CLK_DIV + 1);
   localparam int GAP_W = $clog2(FRAME_GAP + 1);

   localparam logic [HP_W-1:0]  LATCH_LEN = HP_W'(2 * CLK_DIV);
   localparam logic [HP_W-1:0]  HALF_LEN  = HP_W'(CLK_DIV);
   localparam logic [GAP_W-1:0] GAP_LEN   = GAP_W'(FRAME_GAP);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BITS - 1);

   state_e              state_q, state_d;
   logic [NUM_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic                latch_q, latch_d;
   logic                gclk_q,  gclk_d;
   logic                data_q,  data_d;
   logic                busy_q,  busy_d;

   logic                start_frame;
   logic                hp_load;
   logic [HP_W-1:0]     hp_val;
   logic                hp_tc;
   logic                gap_load;
   logic                gap_tc;

   // Half-period timer: times both the latch pulse and each game_clk phase.
   gamepad_pmod_clkdiv #(.WIDTH(HP_W)) u_hp_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (hp_load),
      .load_val_i (hp_val),
      .tc_o       (hp_tc)
   );

   // Gap timer: its strobe marks the last gap cycle, which is exactly frame_done.
   gamepad_pmod_clkdiv #(.WIDTH(GAP_W)) u_gap_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (gap_load),
      .load_val_i (GAP_LEN),
      .tc_o       (gap_tc)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      shift_d     = shift_q;
      idx_d       = idx_q;
      latch_d     = latch_q;
      gclk_d      = gclk_q;
      data_d      = data_q;
      busy_d      = busy_q;
      start_frame = 1'b0;
      hp_load     = 1'b0;
      hp_val      = HALF_LEN;
      gap_load    = 1'b0;

      unique case (state_q)
         IDLE: begin
            start_frame = bus.enable;
         end
         LATCH: begin
            if (hp_tc) begin
               state_d = SHIFT_LO;
               latch_d = 1'b0;
               idx_d   = LAST_IDX;
               data_d  = shift_q[NUM_BITS-1];
               hp_load = 1'b1;
            end
         end
         SHIFT_LO: begin
            if (hp_tc) begin
               state_d = SHIFT_HI;
               gclk_d  = 1'b1;
               hp_load = 1'b1;
            end
         end
         SHIFT_HI: begin
            // Data only moves together with the falling game_clk edge.
            if (hp_tc) begin
               gclk_d = 1'b0;
               if (idx_q != '0) begin
                  state_d = SHIFT_LO;
                  idx_d   = idx_q - IDX_W'(1);
                  data_d  = shift_q[idx_q - IDX_W'(1)];
                  hp_load = 1'b1;
               end else begin
                  state_d  = GAP;
                  data_d   = 1'b0;
                  gap_load = 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_tc) begin
               if (bus.enable) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Back-to-back frames re-enter LATCH straight from GAP with a fresh snapshot.
      if (start_frame) begin
         state_d = LATCH;
         latch_d = 1'b1;
         busy_d  = 1'b1;
         shift_d = {bus.buttons_b, bus.buttons_a};
         hp_load = 1'b1;
         hp_val  = LATCH_LEN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         // NOTE: the snapshot register is small, so it is reset too; no X ever reaches game_data.
         shift_q <= '0;
         idx_q   <= '0;
         latch_q <= 1'b0;
         gclk_q  <= 1'b0;
         data_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         latch_q <= latch_d;
         gclk_q  <= gclk_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.game_latch = latch_q;
   assign bus.game_clk   = gclk_q;
   assign bus.game_data  = data_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = gap_tc;

endmodule

// File: tb/tb_gamepad_pmod_driver.sv
// Self-checking bench for gamepad_pmod_driver (CLK_DIV=4, FRAME_GAP=16).
// A vector table of single frames plus hand-written sequences for reset,
// mid-frame button change, continuous mode, enable drop and mid-frame reset.
module tb_gamepad_pmod_driver;

   localparam int CLK_DIV   = 4;
   localparam int FRAME_GAP = 16;
   localparam int PERIOD    = 2 * CLK_DIV + 48 * CLK_DIV + FRAME_GAP;  // 216

   typedef struct {
      logic [11:0] b;
      logic [11:0] a;
      logic [23:0] exp_word;
   } vec_t;

   typedef struct {
      logic [23:0] word;
      int          rises;
      int          busy_cyc;
      int          fd;
      int          latch_cyc;
      int          viol;
      bit          timeout;
   } frame_res_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   gamepad_pmod_driver_if bus ();

   gamepad_pmod_driver #(
      .CLK_DIV   (CLK_DIV),
      .FRAME_GAP (FRAME_GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the active edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for game_latch, then follows the frame until busy drops.
   // At rising game_clk number mod_at, buttons_a and enable are overwritten.
   task automatic capture(input int mod_at, input logic [11:0] new_a, input logic new_en,
                          output frame_res_t r);
      logic prev_clk;
      logic prev_data;
      int   n;
      r = '{word: '0, rises: 0, busy_cyc: 0, fd: 0, latch_cyc: 0, viol: 0, timeout: 1'b0};
      n = 0;
      while (bus.game_latch !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      if (bus.game_latch !== 1'b1) begin
         r.timeout = 1'b1;
         return;
      end
      prev_clk  = 1'b0;
      prev_data = bus.game_data;
      n = 0;
      while (bus.busy === 1'b1 && n < 2 * PERIOD) begin
         if (bus.game_clk === 1'b1 && prev_clk === 1'b0) begin
            r.word = {r.word[22:0], bus.game_data};
            r.rises++;
            if (r.rises == mod_at) begin
               bus.buttons_a = new_a;
               bus.enable    = new_en;
            end
         end
         if (bus.game_clk === 1'b1 && bus.game_data !== prev_data) r.viol++;
         if (bus.frame_done === 1'b1) r.fd++;
         if (bus.game_latch === 1'b1) r.latch_cyc++;
         r.busy_cyc++;
         prev_clk  = bus.game_clk;
         prev_data = bus.game_data;
         step();
         n++;
      end
      if (bus.busy === 1'b1) r.timeout = 1'b1;
   endtask

   task automatic check_frame(input string name, input frame_res_t r, input logic [23:0] exp_word);
      check({name, "_timeout"}, 32'(r.timeout), 32'd0);
      check({name, "_word"},    32'(r.word),    32'(exp_word));
      check({name, "_rises"},   r.rises,        24);
      check({name, "_busy"},    r.busy_cyc,     PERIOD);
      check({name, "_fdone"},   r.fd,           1);
      check({name, "_latch"},   r.latch_cyc,    2 * CLK_DIV);
      check({name, "_stable"},  r.viol,         0);
   endtask

   task automatic check_all_low(input string name);
      check({name, "_latch"}, 32'(bus.game_latch), 32'd0);
      check({name, "_gclk"},  32'(bus.game_clk),   32'd0);
      check({name, "_data"},  32'(bus.game_data),  32'd0);
      check({name, "_busy"},  32'(bus.busy),       32'd0);
      check({name, "_fdone"}, 32'(bus.frame_done), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs[5];
      frame_res_t r;
      logic       prev;
      int         last;
      int         seen;
      int         busy_low;
      int         cnt;

      vecs[0] = '{b: 12'hA5C, a: 12'h3F1, exp_word: 24'hA5C3F1};
      vecs[1] = '{b: 12'h000, a: 12'h000, exp_word: 24'h000000};
      vecs[2] = '{b: 12'hFFF, a: 12'hFFF, exp_word: 24'hFFFFFF};
      vecs[3] = '{b: 12'h800, a: 12'h001, exp_word: 24'h800001};
      vecs[4] = '{b: 12'h555, a: 12'hAAA, exp_word: 24'h555AAA};

      // 1. Reset held with enable=1: everything stays low.
      bus.enable    = 1'b1;
      bus.buttons_b = 12'h123;
      bus.buttons_a = 12'h456;
      repeat (3) step();
      check_all_low("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rst_first_latch", 32'(bus.game_latch), 32'd1);
      bus.enable = 1'b0;
      capture(-1, 12'h000, 1'b0, r);
      check_frame("rst_frame", r, 24'h123456);

      // 2. Table of single frames, one-cycle enable pulse each.
      for (int i = 0; i < 5; i++) begin
         bus.buttons_b = vecs[i].b;
         bus.buttons_a = vecs[i].a;
         bus.enable    = 1'b1;
         step();
         bus.enable    = 1'b0;
         capture(-1, 12'h000, 1'b0, r);
         check_frame($sformatf("vec%0d", i), r, vecs[i].exp_word);
         check($sformatf("vec%0d_idle", i), 32'(bus.busy), 32'd0);
      end

      // 3. Button change during bit 5 does not touch the frame in flight.
      bus.buttons_b = 12'hA5C;
      bus.buttons_a = 12'h3F1;
      bus.enable    = 1'b1;
      step();
      bus.enable    = 1'b0;
      capture(5, 12'h000, 1'b0, r);
      check_frame("midchg_cur", r, 24'hA5C3F1);
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      capture(-1, 12'h000, 1'b0, r);
      check_frame("midchg_next", r, 24'hA5C000);

      // 4. Continuous mode: latch rises exactly PERIOD apart, busy never drops.
      bus.buttons_b = 12'h1E1;
      bus.buttons_a = 12'h2D2;
      bus.enable    = 1'b1;
      prev     = 1'b0;
      last     = -1;
      seen     = 0;
      busy_low = 0;
      for (int n = 0; n < 4 * PERIOD + 16 && seen < 4; n++) begin
         step();
         if (bus.game_latch === 1'b1 && prev === 1'b0) begin
            if (last >= 0) check($sformatf("cont_period%0d", seen), n - last, PERIOD);
            last = n;
            seen++;
         end
         if (seen > 0 && bus.busy !== 1'b1) busy_low++;
         prev = bus.game_latch;
      end
      check("cont_latches", seen, 4);
      check("cont_busy_low", busy_low, 0);
      bus.enable = 1'b0;
      capture(-1, 12'h000, 1'b0, r);
      check_frame("cont_last", r, 24'h1E12D2);

      // 5. enable dropped at bit 10: frame completes, then idle for good.
      bus.buttons_b = 12'h0F0;
      bus.buttons_a = 12'h70E;
      bus.enable    = 1'b1;
      step();
      capture(10, 12'h70E, 1'b0, r);
      check_frame("endrop", r, 24'h0F070E);
      cnt = 0;
      for (int n = 0; n < 300; n++) begin
         step();
         if (bus.game_latch !== 1'b0 || bus.busy !== 1'b0) cnt++;
      end
      check("endrop_no_relatch", cnt, 0);

      // 6. Reset during SHIFT_HI of bit 12, then a clean frame with a fresh snapshot.
      bus.buttons_b = 12'hA5C;
      bus.buttons_a = 12'h3F1;
      bus.enable    = 1'b1;
      step();
      bus.enable = 1'b0;
      prev = 1'b0;
      cnt  = 0;
      for (int n = 0; n < 2 * PERIOD && cnt < 12; n++) begin
         step();
         if (bus.game_clk === 1'b1 && prev === 1'b0) cnt++;
         prev = bus.game_clk;
      end
      check("rstmid_reached_bit12", cnt, 12);
      check("rstmid_gclk_high", 32'(bus.game_clk), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_low("rstmid_async");
      bus.buttons_b = 12'h3C3;
      bus.buttons_a = 12'h5A5;
      bus.enable    = 1'b1;
      repeat (2) step();
      check_all_low("rstmid_hold");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rstmid_relatch", 32'(bus.game_latch), 32'd1);
      bus.enable = 1'b0;
      capture(-1, 12'h000, 1'b0, r);
      check_frame("rstmid_frame", r, 24'h3C35A5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
